// File: rtl/avalon_byte_master_if.sv
// ---------------------------------------------------------------------------
// avalon_byte_master_if
// Bundles every signal of the byte master except clock and reset.
//   Command stream : cmd_valid, cmd_ready, cmd_write, cmd_addr, cmd_wdata
//   Response stream: rsp_valid, rsp_ready, rsp_write, rsp_rdata, rsp_err
//   Status         : busy, err_count
//   Avalon-MM bus  : address, writedata, readdata, write, read, chipselect,
//                    waitrequest
// Modport master is the byte master's view. Modport slave is the view of
// everything around it: sequencer, response sink and the Avalon slave.
// ---------------------------------------------------------------------------
interface avalon_byte_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;

  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_write;
  logic [7:0] rsp_rdata;
  logic       rsp_err;

  logic       busy;
  logic [7:0] err_count;

  logic [7:0] address;
  logic [7:0] writedata;
  logic [7:0] readdata;
  logic       write;
  logic       read;
  logic       chipselect;
  logic       waitrequest;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           readdata, waitrequest,
    output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
           busy, err_count, address, writedata, write, read, chipselect
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           readdata, waitrequest,
    input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
           busy, err_count, address, writedata, write, read, chipselect
  );
endinterface

// File: rtl/avalon_byte_master.sv
// ---------------------------------------------------------------------------
// avalon_byte_master
// Avalon-MM master for an 8-bit slave port, driven by a command/response
// stream. Commands are buffered in a small FIFO; each one becomes exactly one
// Avalon transfer, held while waitrequest is high, and yields exactly one
// response carrying read data or a timeout error. Only one transfer is ever
// outstanding, so responses come back in command order.
// Ports:
//   clk     : single clock
//   reset_n : asynchronous active-low reset
//   bus     : avalon_byte_master_if.master (command, response, status and
//             Avalon signals)
// Every output is driven straight from a flop.
// ---------------------------------------------------------------------------
module avalon_byte_master #(
  parameter int CMD_FIFO_DEPTH = 4,
  parameter int CMD_FIFO_AW    = 2,
  parameter int TIMEOUT        = 256,
  parameter int TO_CNT_W       = 9
) (
  input logic                  clk,
  input logic                  reset_n,
  avalon_byte_master_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
  } cmd_entry_t;

  localparam logic [CMD_FIFO_AW:0]  DEPTH_C   = (CMD_FIFO_AW + 1)'(CMD_FIFO_DEPTH);
  localparam logic [TO_CNT_W-1:0]   TO_LAST_C = TO_CNT_W'(TIMEOUT - 1);

  state_e                 state_q, state_d;
  cmd_entry_t             fifo_mem [CMD_FIFO_DEPTH];
  logic [CMD_FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CMD_FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CMD_FIFO_AW:0]   count_q, count_d;
  logic [TO_CNT_W-1:0]    to_cnt_q, to_cnt_d;
  logic [7:0]             address_q, address_d;
  logic [7:0]             writedata_q, writedata_d;
  logic                   read_q, read_d;
  logic                   write_q, write_d;
  logic                   chipselect_q;
  logic                   rsp_valid_q, rsp_valid_d;
  logic                   rsp_write_q, rsp_write_d;
  logic                   rsp_err_q, rsp_err_d;
  logic [7:0]             rsp_rdata_q, rsp_rdata_d;
  logic [7:0]             err_count_q, err_count_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   busy_q, busy_d;
  logic                   push_s;
  logic                   pop_s;
  cmd_entry_t             head_s;

  // cmd_ready is a flop that reflects only the FIFO fill level, so a pop in
  // the same cycle can never let an extra command in.
  assign push_s = bus.cmd_valid & cmd_ready_q;
  assign head_s = fifo_mem[rd_ptr_q];

  // FIFO storage: holds only data, validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem[wr_ptr_q] <= '{wr: bus.cmd_write, addr: bus.cmd_addr, wdata: bus.cmd_wdata};
    end
  end

  // FIFO pointers, fill count and the registered ready/busy flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + CMD_FIFO_AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + CMD_FIFO_AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (CMD_FIFO_AW + 1)'(1);
      2'b01:   count_d = count_q - (CMD_FIFO_AW + 1)'(1);
      default: count_d = count_q;
    endcase
    cmd_ready_d = (count_d != DEPTH_C);
    busy_d      = (state_d != ST_IDLE) || (count_d != '0);
  end

  // Transfer FSM: next state plus next values of every bus/response flop.
  always_comb begin
    state_d     = state_q;
    pop_s       = 1'b0;
    to_cnt_d    = to_cnt_q;
    address_d   = address_q;
    writedata_d = writedata_q;
    read_d      = read_q;
    write_d     = write_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    err_count_d = err_count_q;
    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          pop_s       = 1'b1;
          address_d   = head_s.addr;
          writedata_d = head_s.wr ? head_s.wdata : 8'h00;
          write_d     = head_s.wr;
          read_d      = ~head_s.wr;
          to_cnt_d    = '0;
          state_d     = ST_BUS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUS: begin
        // A completing slave wins over a timeout landing in the same cycle.
        if (!bus.waitrequest) begin
          rsp_rdata_d = read_q ? bus.readdata : 8'h00;
          read_d      = 1'b0;
          write_d     = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_write_d = write_q;
          state_d     = ST_RESP;
        end else if (to_cnt_q == TO_LAST_C) begin
          to_cnt_d    = to_cnt_q + TO_CNT_W'(1);
          rsp_rdata_d = 8'h00;
          read_d      = 1'b0;
          write_d     = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_write_d = write_q;
          if (err_count_q != 8'hFF) begin
            err_count_d = err_count_q + 8'd1;
          end else begin
            err_count_d = err_count_q;
          end
          state_d = ST_RESP;
        end else begin
          to_cnt_d = to_cnt_q + TO_CNT_W'(1);
          state_d  = ST_BUS;
        end
      end
      ST_RESP: begin
        // rsp_valid is always high in this state, so rsp_ready alone completes it.
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        read_d      = 1'b0;
        write_d     = 1'b0;
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State, FIFO bookkeeping and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      to_cnt_q     <= '0;
      address_q    <= 8'h00;
      writedata_q  <= 8'h00;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      chipselect_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_write_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_rdata_q  <= 8'h00;
      err_count_q  <= 8'h00;
      cmd_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      to_cnt_q     <= to_cnt_d;
      address_q    <= address_d;
      writedata_q  <= writedata_d;
      read_q       <= read_d;
      write_q      <= write_d;
      chipselect_q <= read_d | write_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_write_q  <= rsp_write_d;
      rsp_err_q    <= rsp_err_d;
      rsp_rdata_q  <= rsp_rdata_d;
      err_count_q  <= err_count_d;
      cmd_ready_q  <= cmd_ready_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_write  = rsp_write_q;
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.busy       = busy_q;
  assign bus.err_count  = err_count_q;
  assign bus.address    = address_q;
  assign bus.writedata  = writedata_q;
  assign bus.write      = write_q;
  assign bus.read       = read_q;
  assign bus.chipselect = chipselect_q;

endmodule

// File: tb/tb_avalon_byte_master.sv
// ---------------------------------------------------------------------------
// tb_avalon_byte_master
// Directed bench for avalon_byte_master with a register-file Avalon slave.
// Expected responses come from a bench-side register model updated in
// command order.
// ---------------------------------------------------------------------------
module tb_avalon_byte_master;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  avalon_byte_master_if bus();

  avalon_byte_master #(
    .CMD_FIFO_DEPTH(4),
    .CMD_FIFO_AW   (2),
    .TIMEOUT       (256),
    .TO_CNT_W      (9)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct packed {
    logic       wr;
    logic [7:0] rdata;
    logic       err;
  } rsp_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   viol     = 0;
  rsp_t exp_q[$];
  logic [7:0] ref_regs [256];
  logic [7:0] slv_regs [256];
  bit   stuck     = 1'b0;
  bit   rand_mode = 1'b0;
  int   stall_n   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Avalon register-file slave: programmable or random wait states, or stuck.
  initial begin
    bit active;
    int wcnt;
    int cur_stall;
    active = 1'b0;
    wcnt = 0;
    cur_stall = 0;
    bus.waitrequest = 1'b0;
    bus.readdata = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.read || bus.write) begin
        if (!active) begin
          active = 1'b1;
          wcnt = 0;
          cur_stall = rand_mode ? int'($urandom_range(0, 3)) : stall_n;
        end
        if (stuck || wcnt < cur_stall) begin
          bus.waitrequest = 1'b1;
          bus.readdata = 8'h00;
          wcnt++;
        end else begin
          bus.waitrequest = 1'b0;
          bus.readdata = bus.read ? slv_regs[bus.address] : 8'h00;
          if (bus.write) slv_regs[bus.address] = bus.writedata;
        end
      end else begin
        active = 1'b0;
        bus.waitrequest = 1'b0;
        bus.readdata = 8'h00;
      end
    end
  end

  // Bus rule monitor: strobes exclusive, chipselect consistent, quiet during a response.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if ((bus.read && bus.write) ||
            (bus.chipselect != (bus.read | bus.write)) ||
            (bus.rsp_valid && (bus.read || bus.write || bus.chipselect))) viol++;
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic w, input logic [7:0] a, input logic [7:0] d);
    int guard;
    guard = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    while (!bus.cmd_ready && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 3000) begin
      check_eq("push_timeout", 32'(guard), 32'd0);
    end else if (stuck) begin
      exp_q.push_back('{wr: w, rdata: 8'h00, err: 1'b1});
    end else begin
      exp_q.push_back('{wr: w, rdata: (w ? 8'h00 : ref_regs[a]), err: 1'b0});
      if (w) ref_regs[a] = d;
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic collect(input int n, input bit rnd);
    int   guard;
    bit   got;
    rsp_t e;
    for (int k = 0; k < n; k++) begin
      guard = 0;
      got = 1'b0;
      while (!got && guard < 3000) begin
        bus.rsp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (bus.rsp_valid && bus.rsp_ready) begin
          got = 1'b1;
          check_eq("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("rsp_write", 32'(bus.rsp_write), 32'(e.wr));
            check_eq("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.rdata));
            check_eq("rsp_err",   32'(bus.rsp_err),   32'(e.err));
          end
        end
        @(negedge clk);
        guard++;
      end
      if (!got) check_eq("rsp_timeout", 32'(guard), 32'd0);
    end
    bus.rsp_ready = 1'b0;
  endtask

  // Counts cycles with read high until a response appears.
  task automatic count_read_cycles(output int cnt);
    int guard;
    cnt = 0;
    guard = 0;
    while (!bus.rsp_valid && guard < 400) begin
      @(negedge clk);
      if (bus.read) cnt++;
      guard++;
    end
  endtask

  task automatic run_random();
    int gap;
    rand_mode = 1'b1;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          gap = int'($urandom_range(0, 2));
          repeat (gap) @(negedge clk);
          push(1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom));
        end
      end
      collect(40, 1'b1);
    join
    rand_mode = 1'b0;
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < 256; i++) begin
      ref_regs[i] = 8'(i) ^ 8'h5A;
      slv_regs[i] = 8'(i) ^ 8'h5A;
    end
    ref_regs[8'h10] = 8'h3C;
    slv_regs[8'h10] = 8'h3C;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 8'h00;
    bus.cmd_wdata = 8'h00;
    bus.rsp_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_write",      32'(bus.write),      32'd0);
    check_eq("rst_read",       32'(bus.read),       32'd0);
    check_eq("rst_chipselect", 32'(bus.chipselect), 32'd0);
    check_eq("rst_rsp_valid",  32'(bus.rsp_valid),  32'd0);
    check_eq("rst_address",    32'(bus.address),    32'd0);
    check_eq("rst_err_count",  32'(bus.err_count),  32'd0);
    check_eq("rst_busy",       32'(bus.busy),       32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("rst_cmd_ready",  32'(bus.cmd_ready),  32'd1);

    // Zero-wait write: strobes one cycle after the push edge, response one later
    stall_n = 0;
    push(1'b1, 8'h03, 8'hA5);
    check_eq("wr_early_strobe", 32'(bus.write), 32'd0);
    @(negedge clk);
    check_eq("wr_strobe",    32'(bus.write),      32'd1);
    check_eq("wr_cs",        32'(bus.chipselect), 32'd1);
    check_eq("wr_address",   32'(bus.address),    32'h03);
    check_eq("wr_writedata", 32'(bus.writedata),  32'hA5);
    check_eq("wr_rsp_early", 32'(bus.rsp_valid),  32'd0);
    @(negedge clk);
    check_eq("wr_rsp_valid", 32'(bus.rsp_valid),  32'd1);
    check_eq("wr_strobe_off",32'(bus.write),      32'd0);
    collect(1, 1'b0);
    check_eq("wr_slave_reg", 32'(slv_regs[8'h03]), 32'hA5);

    // Read with five wait states
    stall_n = 5;
    push(1'b0, 8'h10, 8'hFF);
    count_read_cycles(cnt);
    check_eq("rd_held_cycles", 32'(cnt), 32'd6);
    collect(1, 1'b0);
    stall_n = 0;

    // Fill the FIFO with responses stalled: 4 queued plus 1 in flight
    push(1'b1, 8'h20, 8'h11);
    push(1'b1, 8'h21, 8'h22);
    push(1'b0, 8'h20, 8'h00);
    push(1'b0, 8'h21, 8'h00);
    push(1'b1, 8'h22, 8'h33);
    check_eq("full_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check_eq("full_busy",      32'(bus.busy),      32'd1);
    check_eq("full_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    repeat (3) @(negedge clk);
    check_eq("full_held",      32'(bus.cmd_ready), 32'd0);
    collect(5, 1'b0);
    @(negedge clk);
    check_eq("drained_busy",   32'(bus.busy),      32'd0);
    check_eq("drained_ready",  32'(bus.cmd_ready), 32'd1);

    // Random traffic against the register-file slave
    run_random();
    check_eq("rand_no_leftover", 32'(exp_q.size()), 32'd0);
    for (int a = 0; a < 8; a++) begin
      check_eq("rand_reg_match", 32'(slv_regs[a]), 32'(ref_regs[a]));
    end

    // Timeout: stuck waitrequest aborts after 256 cycles in BUS
    stuck = 1'b1;
    push(1'b0, 8'h40, 8'h00);
    count_read_cycles(cnt);
    check_eq("to_bus_cycles", 32'(cnt), 32'd256);
    collect(1, 1'b0);
    check_eq("to_err_count_1", 32'(bus.err_count), 32'd1);
    for (int i = 0; i < 258; i++) begin
      push(1'b0, 8'h40, 8'h00);
      collect(1, 1'b0);
    end
    check_eq("to_err_count_sat", 32'(bus.err_count), 32'd255);

    // Async reset mid-transfer
    push(1'b1, 8'h05, 8'h77);
    @(negedge clk);
    check_eq("mid_write", 32'(bus.write), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("async_write_drop", 32'(bus.write),      32'd0);
    check_eq("async_cs_drop",    32'(bus.chipselect), 32'd0);
    exp_q.delete();
    stuck = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_busy",      32'(bus.busy),      32'd0);
    check_eq("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check_eq("post_rst_err_count", 32'(bus.err_count), 32'd0);
    check_eq("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);

    check_eq("strobe_rules", 32'(viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
